// File: rtl/regfile_wb_sequencer_if.sv
// Write-back request channel (memory stage -> sequencer) and register-file write port.
// Slave side is the sequencer; master side is whoever drives requests and observes writes.
interface regfile_wb_sequencer_if #(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 4
);
    logic               wb_valid;
    logic               wb_ready;
    logic [3:0]         wb_icode;
    logic [RADDR_W-1:0] wb_rA;
    logic [RADDR_W-1:0] wb_rB;
    logic [DATA_W-1:0]  wb_valE;
    logic [DATA_W-1:0]  wb_valM;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;

    modport master (
        output wb_valid, wb_icode, wb_rA, wb_rB, wb_valE, wb_valM,
        input  wb_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_icode, wb_rA, wb_rB, wb_valE, wb_valM,
        output wb_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Expands one write-back request into 0-2 ordered register writes, tracking pending destinations.
// Latency: accept at edge N -> first write in cycle N+1, popq second write in N+2; wb_err in N+1.
// Backpressure: wb_ready drops only while a popq's first write is in flight. Bypass: REGFILE_WB_BYPASS_EN.
module regfile_wb_sequencer #(
    parameter int               DATA_W  = 64,
    parameter int               RADDR_W = 4,
    parameter logic [RADDR_W-1:0] SP_IDX = 4'd4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_sequencer_if.slave bus,
    input  logic [RADDR_W-1:0] rd_addr_a,
    input  logic [RADDR_W-1:0] rd_addr_b,
    output logic               hazard_a,
    output logic               hazard_b,
`ifdef REGFILE_WB_BYPASS_EN
    output logic [DATA_W-1:0]  byp_a_data,
    output logic [DATA_W-1:0]  byp_b_data,
`endif
    output logic               busy,
    output logic               wb_err
);
    localparam logic [RADDR_W-1:0] NO_REG = '1;

    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    state_t             state_q, state_d;
    logic               slot0_vld_q, slot1_vld_q;
    logic [RADDR_W-1:0] slot0_idx_q, slot1_idx_q;
    logic [DATA_W-1:0]  slot0_dat_q, slot1_dat_q;
    logic               wb_err_q;

    logic               new0_vld, new1_vld, new_drop;
    logic [RADDR_W-1:0] new0_idx, new1_idx;
    logic [DATA_W-1:0]  new0_dat, new1_dat;

    logic               ready, accept, we;
    logic [RADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;

    // Slot0 always holds the first write, so a popq's rsp update lands before its rA update.
    always_comb begin
        new0_vld = 1'b0;
        new1_vld = 1'b0;
        new_drop = 1'b0;
        new0_idx = NO_REG;
        new1_idx = NO_REG;
        new0_dat = '0;
        new1_dat = '0;
        case (bus.wb_icode)
            4'h2, 4'h3, 4'h6: begin
                new0_idx = bus.wb_rB;
                new0_dat = bus.wb_valE;
                new0_vld = (bus.wb_rB != NO_REG);
                new_drop = (bus.wb_rB == NO_REG);
            end
            4'h5: begin
                new0_idx = bus.wb_rB;
                new0_dat = bus.wb_valM;
                new0_vld = (bus.wb_rB != NO_REG);
                new_drop = (bus.wb_rB == NO_REG);
            end
            4'h8, 4'h9, 4'hA: begin
                new0_idx = SP_IDX;
                new0_dat = bus.wb_valE;
                new0_vld = 1'b1;
            end
            4'hB: begin
                new0_idx = SP_IDX;
                new0_dat = bus.wb_valE;
                new0_vld = 1'b1;
                new1_idx = bus.wb_rA;
                new1_dat = bus.wb_valM;
                new1_vld = (bus.wb_rA != NO_REG);
                new_drop = (bus.wb_rA == NO_REG);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        we      = 1'b0;
        waddr   = NO_REG;
        wdata   = '0;
        case (state_q)
            IDLE:    ready = 1'b1;
            WR0: begin
                ready = !slot1_vld_q;
                we    = 1'b1;
                waddr = slot0_idx_q;
                wdata = slot0_dat_q;
            end
            WR1: begin
                ready = 1'b1;
                we    = 1'b1;
                waddr = slot1_idx_q;
                wdata = slot1_dat_q;
            end
            default: ready = 1'b0;
        endcase
        accept = bus.wb_valid && ready;
        if (state_q == WR0 && slot1_vld_q) begin
            state_d = WR1;
        end else if (accept && new0_vld) begin
            state_d = WR0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot0_vld_q <= 1'b0;
            slot1_vld_q <= 1'b0;
            slot0_idx_q <= NO_REG;
            slot1_idx_q <= NO_REG;
            slot0_dat_q <= '0;
            slot1_dat_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_err_q <= accept && new_drop;
            if (accept) begin
                slot0_vld_q <= new0_vld;
                slot1_vld_q <= new1_vld;
                slot0_idx_q <= new0_idx;
                slot1_idx_q <= new1_idx;
                slot0_dat_q <= new0_dat;
                slot1_dat_q <= new1_dat;
            end else begin
                if (state_q == WR0) slot0_vld_q <= 1'b0;
                if (state_q == WR1) slot1_vld_q <= 1'b0;
            end
        end
    end

    // A slot stays valid through its own write cycle, so the in-flight write still flags a hazard.
    logic a_m0, a_m1, b_m0, b_m1;
    assign a_m0 = (rd_addr_a != NO_REG) && slot0_vld_q && (slot0_idx_q == rd_addr_a);
    assign a_m1 = (rd_addr_a != NO_REG) && slot1_vld_q && (slot1_idx_q == rd_addr_a);
    assign b_m0 = (rd_addr_b != NO_REG) && slot0_vld_q && (slot0_idx_q == rd_addr_b);
    assign b_m1 = (rd_addr_b != NO_REG) && slot1_vld_q && (slot1_idx_q == rd_addr_b);

    assign hazard_a = a_m0 || a_m1;
    assign hazard_b = b_m0 || b_m1;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_a_data = a_m1 ? slot1_dat_q : (a_m0 ? slot0_dat_q : '0);
    assign byp_b_data = b_m1 ? slot1_dat_q : (b_m0 ? slot0_dat_q : '0);
`endif

    assign busy         = (state_q != IDLE);
    assign wb_err       = wb_err_q;
    assign bus.wb_ready = ready;
    assign bus.rf_we    = we;
    assign bus.rf_waddr = waddr;
    assign bus.rf_wdata = wdata;
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed vector table, reset-abort sequence, then random
// traffic checked against a queue-of-pending-writes reference model.
module tb_regfile_wb_sequencer;
    localparam logic [3:0] NR = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] rd_addr_a, rd_addr_b;
    logic hazard_a, hazard_b, busy, wb_err;
`ifdef REGFILE_WB_BYPASS_EN
    logic [63:0] byp_a_data, byp_b_data;
`endif

    regfile_wb_sequencer_if #(.DATA_W(64), .RADDR_W(4)) bus ();

    regfile_wb_sequencer #(.DATA_W(64), .RADDR_W(4), .SP_IDX(4'd4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
`ifdef REGFILE_WB_BYPASS_EN
        .byp_a_data(byp_a_data),
        .byp_b_data(byp_b_data),
`endif
        .busy      (busy),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  icode, ra, rb;
        logic [63:0] vale, valm;
        logic [3:0]  rd_a, rd_b;
        logic        we;
        logic [3:0]  waddr;
        logic [63:0] wdata;
        logic        rdy, haz_a, haz_b, busy, err;
        logic [63:0] byp_a, byp_b;
    } vec_t;

    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
    } wr_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[20];
    wr_t  wq[$];
    logic err_exp;

    task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, required 0x%0h", tag, nm, act, exp);
        end
    endtask

    // Drive a row's inputs, check outputs mid-cycle, then advance past the next edge.
    task automatic run_cycle(input vec_t v, input string tag);
        bus.wb_valid = v.vld;
        bus.wb_icode = v.icode;
        bus.wb_rA    = v.ra;
        bus.wb_rB    = v.rb;
        bus.wb_valE  = v.vale;
        bus.wb_valM  = v.valm;
        rd_addr_a    = v.rd_a;
        rd_addr_b    = v.rd_b;
        #2;
        chk(tag, "rf_we",    64'(bus.rf_we),    64'(v.we));
        chk(tag, "rf_waddr", 64'(bus.rf_waddr), 64'(v.waddr));
        chk(tag, "rf_wdata", bus.rf_wdata,      v.wdata);
        chk(tag, "wb_ready", 64'(bus.wb_ready), 64'(v.rdy));
        chk(tag, "hazard_a", 64'(hazard_a),     64'(v.haz_a));
        chk(tag, "hazard_b", 64'(hazard_b),     64'(v.haz_b));
        chk(tag, "busy",     64'(busy),         64'(v.busy));
        chk(tag, "wb_err",   64'(wb_err),       64'(v.err));
`ifdef REGFILE_WB_BYPASS_EN
        chk(tag, "byp_a", byp_a_data, v.byp_a);
        chk(tag, "byp_b", byp_b_data, v.byp_b);
`endif
        @(posedge clk);
        #1;
    endtask

    // Reference expansion of one accepted request into the pending-write queue.
    task automatic expand(input vec_t v, output logic drop);
        drop = 1'b0;
        case (v.icode)
            4'h2, 4'h3, 4'h6: if (v.rb == NR) drop = 1'b1; else wq.push_back('{v.rb, v.vale});
            4'h5:             if (v.rb == NR) drop = 1'b1; else wq.push_back('{v.rb, v.valm});
            4'h8, 4'h9, 4'hA: wq.push_back('{4'd4, v.vale});
            4'hB: begin
                wq.push_back('{4'd4, v.vale});
                if (v.ra == NR) drop = 1'b1; else wq.push_back('{v.ra, v.valm});
            end
            default: ;
        endcase
    endtask

    function automatic logic [64:0] lookup(input logic [3:0] rd);
        logic [64:0] r = '0;
        if (rd != NR)
            foreach (wq[i]) if (wq[i].a == rd) r = {1'b1, wq[i].d};
        return r;
    endfunction

    initial begin
        logic [3:0] icodes[12];
        vec_t v;
        logic drop;
        logic [64:0] la, lb;

        icodes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
        // vld icode ra rb vale valm rd_a rd_b | we waddr wdata rdy haz_a haz_b busy err byp_a byp_b
        tbl[0]  = '{1'b1, 4'h6, 4'h0, 4'h2, 64'h1234, 64'h0,  4'h2, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h2, NR,   1'b1, 4'h2, 64'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1234, 64'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h2, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[3]  = '{1'b1, 4'hB, 4'h3, 4'h0, 64'h400,  64'hAB, 4'h3, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h3, 4'h4, 1'b1, 4'h4, 64'h400,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'hAB,   64'h400};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h3, 4'h4, 1'b1, 4'h3, 64'hAB,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hAB,   64'h0};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h3, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[7]  = '{1'b1, 4'hB, 4'h4, 4'h0, 64'h500,  64'hCD, 4'h4, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h4, NR,   1'b1, 4'h4, 64'h500,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hCD,   64'h0};
        tbl[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h4, NR,   1'b1, 4'h4, 64'hCD,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hCD,   64'h0};
        tbl[10] = '{1'b1, 4'h9, NR,   4'h0, 64'h408,  64'h0,  4'h4, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[11] = '{1'b1, 4'h3, NR,   NR,   64'h408,  64'h0,  4'h4, NR,   1'b1, 4'h4, 64'h408,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h408,  64'h0};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h4, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,    64'h0};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h4, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[14] = '{1'b1, 4'h2, 4'h0, 4'h1, 64'h11,   64'h0,  4'h5, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[15] = '{1'b1, 4'h2, 4'h0, 4'h5, 64'h55,   64'h0,  4'h5, NR,   1'b1, 4'h1, 64'h11,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,    64'h0};
        tbl[16] = '{1'b1, 4'h2, 4'h0, 4'h7, 64'h77,   64'h0,  4'h5, NR,   1'b1, 4'h5, 64'h55,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h55,   64'h0};
        tbl[17] = '{1'b1, 4'h1, 4'h0, 4'h0, 64'h0,    64'h0,  4'h7, NR,   1'b1, 4'h7, 64'h77,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h77,   64'h0};
        tbl[18] = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h7, NR,   1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};
        tbl[19] = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0,    64'h0,  4'h0, 4'h0, 1'b0, NR,   64'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    64'h0};

        bus.wb_valid = 1'b0;
        bus.wb_icode = 4'h0;
        bus.wb_rA    = 4'h0;
        bus.wb_rB    = 4'h0;
        bus.wb_valE  = 64'h0;
        bus.wb_valM  = 64'h0;
        rd_addr_a    = NR;
        rd_addr_b    = NR;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_cycle(tbl[i], $sformatf("row%0d", i));

        // Reset during the first write of a popq must drop the pending rA write.
        v = '{1'b1, 4'hB, 4'h3, 4'h0, 64'h400, 64'hAB, 4'h3, NR, 1'b0, NR, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        run_cycle(v, "rst_accept");
        rst = 1'b1;
        v = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h3, NR, 1'b1, 4'h4, 64'h400, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hAB, 64'h0};
        run_cycle(v, "rst_wr0");
        rst = 1'b0;
        v = '{1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h3, 4'h4, 1'b0, NR, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
        run_cycle(v, "rst_after1");
        run_cycle(v, "rst_after2");

        err_exp = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v.vld   = ($urandom_range(0, 9) < 7);
            v.icode = icodes[$urandom_range(0, 11)];
            v.ra    = ($urandom_range(0, 3) == 0) ? NR : 4'($urandom_range(0, 14));
            v.rb    = ($urandom_range(0, 3) == 0) ? NR : 4'($urandom_range(0, 14));
            v.vale  = {$urandom, $urandom};
            v.valm  = {$urandom, $urandom};
            v.rd_a  = 4'($urandom_range(0, 15));
            v.rd_b  = 4'($urandom_range(0, 15));
            v.we    = (wq.size() != 0);
            v.waddr = v.we ? wq[0].a : NR;
            v.wdata = v.we ? wq[0].d : 64'h0;
            v.rdy   = (wq.size() <= 1);
            v.busy  = v.we;
            v.err   = err_exp;
            la      = lookup(v.rd_a);
            lb      = lookup(v.rd_b);
            v.haz_a = la[64];
            v.haz_b = lb[64];
            v.byp_a = la[63:0];
            v.byp_b = lb[63:0];
            run_cycle(v, $sformatf("rnd%0d", c));
            if (wq.size() != 0) void'(wq.pop_front());
            err_exp = 1'b0;
            if (v.vld && v.rdy) begin
                expand(v, drop);
                err_exp = drop;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
